ps2_host_rx: RTL and testbench
==============================

Name: ps2_host_rx

Overview:
Core-side PS/2 receiver. It decodes the ps2_kbd_clk/ps2_kbd_data (or mouse) serial stream driven by the MiST I/O block into bytes, and turns keyboard prefix sequences into key events. It sits between the I/O block's PS/2 outputs and the machine keyboard matrix logic, in the clk_sys domain. It filters the PS/2 clock, checks framing and parity, and recovers from a stalled frame with a timeout.

Parameters:
FILTER_LEN, 8, consecutive identical clk_sys samples required before the filtered ps2_clk changes level
TIMEOUT, 4096, clk_sys cycles without a filtered falling edge before a frame in progress is aborted
TIMEOUT_BITS, 13, width of the timeout counter; must hold TIMEOUT

Ports:
clk_sys  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
ps2_clk  in  1  PS/2 clock from the I/O block, asynchronous; idles high
ps2_data  in  1  PS/2 data, asynchronous; idles high
byte_valid  out  1  one-cycle strobe: byte_data holds a correctly framed byte
byte_data  out  8  last good byte received
frame_err  out  1  one-cycle strobe on a parity, stop-bit or timeout error
key_strobe  out  1  one-cycle strobe: a complete key event is available
key_code  out  8  scancode of the event (prefixes stripped)
key_extended  out  1  event was preceded by E0
key_released  out  1  event was preceded by F0

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE; filtered clk=1; sync flops=1; filter/timeout/bit counters=0; ext and rel flags=0; every output=0. A partial frame is discarded without raising frame_err.
- Input synchronisation: ps2_clk and ps2_data each pass through a 2-flop synchroniser.
- Clock filter: a counter increments while the synchronised clk differs from the filtered clk, and clears otherwise. When the count reaches FILTER_LEN-1, the filtered clk toggles and the counter clears. Pulses shorter than FILTER_LEN cycles are ignored.
- Sample event: filtered clk goes 1->0. Data is the synchronised ps2_data in that same cycle.
- FSM, advancing only on sample events (except timeout):
  - IDLE: data=0 -> DATA with bit_cnt=0. data=1 -> stay in IDLE (no error).
  - DATA: shift right, taking the LSB first into shreg[7]; bit_cnt++. After the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: go to IDLE. Good frame = (^shreg ^ parity)==1 (odd parity) and data=1.
    - Good frame: byte_data<=shreg, and byte_valid pulses in the next cycle (one cycle after the stop-bit sample event).
    - Bad frame: frame_err pulses in the same relative cycle, and byte_data is unchanged.
- Timeout: the counter clears on every sample event and while in IDLE, and otherwise increments. On reaching TIMEOUT-1 outside IDLE: go to IDLE, pulse frame_err, clear the ext and rel flags. If a sample event coincides with timeout expiry, the sample event wins and no error is raised.
- Key decoder, acting on each good byte:
  - E0: ext<=1, no key_strobe.
  - F0: rel<=1, no key_strobe.
  - Any other value, including E1 and AA: in the same cycle as byte_valid, key_strobe=1, key_code=byte, key_extended=ext, key_released=rel. Then clear ext and rel.
- key_code, key_extended and key_released hold their values until the next key_strobe.
- frame_err always clears ext and rel.
- byte_valid pulses for every good byte, including prefix bytes.
- The block is fully streaming, with no FIFO and no back-pressure. Back-to-back frames are accepted as fast as the filtered clock allows.

Test Plan:
- Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1), half-period 101 clk_sys -> one byte_valid with byte_data=0x1C. Same cycle: key_strobe, key_code=0x1C, key_extended=0, key_released=0. No frame_err.
- Frames E0, F0, 0x75 back-to-back -> byte_valid three times. Exactly one key_strobe, on the third, with key_code=0x75, key_extended=1, key_released=1. A following 0x75 frame -> key_strobe with extended=0, released=0.
- 0x1C frame with parity bit 1, and separately with stop bit 0 -> each gives a frame_err pulse and no byte_valid or key_strobe; byte_data keeps its previous value.
- 3-cycle low glitch on ps2_clk while idle and mid-frame, FILTER_LEN=8 -> no bit sampled. The subsequent 0x29 frame decodes correctly.
- Send E0, then only start bit plus 4 data bits, then idle for TIMEOUT+10 cycles -> frame_err exactly once, FSM returns to IDLE, ext flag cleared. The next 0x29 frame gives key_code=0x29, key_extended=0.
- Assert reset after 6 data bits for 1 cycle -> all outputs 0 and no frame_err. A complete 0x5A frame afterwards -> byte_valid with byte_data=0x5A.

Source files
------------

// File: rtl/ps2_host_rx_if.sv
// PS/2 receiver bus: raw serial lines in, decoded byte and key events out.
// The slave side is the receiver; the master side drives the lines and consumes events.
interface ps2_host_rx_if;
  logic       i_ps2_clk;
  logic       i_ps2_data;
  logic       o_byte_valid;
  logic [7:0] o_byte_data;
  logic       o_frame_err;
  logic       o_key_strobe;
  logic [7:0] o_key_code;
  logic       o_key_extended;
  logic       o_key_released;

  modport slave (
    input  i_ps2_clk, i_ps2_data,
    output o_byte_valid, o_byte_data, o_frame_err,
    output o_key_strobe, o_key_code, o_key_extended, o_key_released
  );

  modport master (
    output i_ps2_clk, i_ps2_data,
    input  o_byte_valid, o_byte_data, o_frame_err,
    input  o_key_strobe, o_key_code, o_key_extended, o_key_released
  );
endinterface

// File: rtl/ps2_host_rx.sv
// Core-side PS/2 receiver: synchronise and filter the PS/2 clock, deframe bytes
// with odd parity and stall timeout, and fold E0/F0 prefixes into key events.
module ps2_host_rx #(
  parameter int FILTER_LEN   = 8,
  parameter int TIMEOUT      = 4096,
  parameter int TIMEOUT_BITS = 13
) (
  input  logic         i_clk_sys,
  input  logic         i_reset,
  ps2_host_rx_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                  r_state, w_state_nxt;
  logic [1:0]              r_clk_sync, r_dat_sync;
  logic                    w_clk_s, w_dat_s;
  logic                    r_filt_clk;
  logic [FW-1:0]           r_filt_cnt;
  logic                    w_filt_tgl, w_sample;
  logic [TIMEOUT_BITS-1:0] r_to_cnt;
  logic                    w_timeout;
  logic [7:0]              r_shreg;
  logic [2:0]              r_bit_cnt;
  logic                    r_parity;
  logic                    w_good, w_bad, w_err;
  logic                    r_ext, r_rel;
  logic                    r_byte_valid, r_frame_err, r_key_strobe;
  logic [7:0]              r_byte_data, r_key_code;
  logic                    r_key_ext, r_key_rel;

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], bus.i_ps2_clk};
      r_dat_sync <= {r_dat_sync[0], bus.i_ps2_data};
    end
  end

  assign w_clk_s = r_clk_sync[1];
  assign w_dat_s = r_dat_sync[1];

  // Filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
  assign w_filt_tgl = (w_clk_s != r_filt_clk) && (r_filt_cnt == FW'(FILTER_LEN - 1));
  assign w_sample   = w_filt_tgl & r_filt_clk;

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
    end else if (w_clk_s == r_filt_clk) begin
      r_filt_cnt <= '0;
    end else if (w_filt_tgl) begin
      r_filt_clk <= ~r_filt_clk;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + 1'b1;
    end
  end

  // A sample event in the expiry cycle takes priority over the timeout.
  assign w_timeout = (r_state != S_IDLE) && !w_sample &&
                     (r_to_cnt == TIMEOUT_BITS'(TIMEOUT - 1));

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset)                                     r_to_cnt <= '0;
    else if (w_sample || r_state == S_IDLE || w_timeout) r_to_cnt <= '0;
    else                                             r_to_cnt <= r_to_cnt + 1'b1;
  end

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end else if (w_sample) begin
      case (r_state)
        S_IDLE:   if (!w_dat_s) w_state_nxt = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_good = 1'b0;
    w_bad  = 1'b0;
    if (w_sample && r_state == S_STOP) begin
      if (((^r_shreg) ^ r_parity) && w_dat_s) w_good = 1'b1;
      else                                    w_bad  = 1'b1;
    end
    w_err = w_bad | w_timeout;
  end

  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_parity  <= 1'b0;
    end else if (w_sample) begin
      case (r_state)
        S_IDLE:   r_bit_cnt <= '0;
        S_DATA: begin
          r_shreg   <= {w_dat_s, r_shreg[7:1]};
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
        S_PARITY: r_parity <= w_dat_s;
        default:  ;
      endcase
    end
  end

  // Prefix bytes only arm flags; any other good byte emits the key event.
  always_ff @(posedge i_clk_sys or posedge i_reset) begin
    if (i_reset) begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_key_strobe <= 1'b0;
      r_byte_data  <= '0;
      r_key_code   <= '0;
      r_key_ext    <= 1'b0;
      r_key_rel    <= 1'b0;
      r_ext        <= 1'b0;
      r_rel        <= 1'b0;
    end else begin
      r_byte_valid <= w_good;
      r_frame_err  <= w_err;
      r_key_strobe <= 1'b0;
      if (w_good) begin
        r_byte_data <= r_shreg;
        if (r_shreg == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_shreg == 8'hF0) begin
          r_rel <= 1'b1;
        end else begin
          r_key_strobe <= 1'b1;
          r_key_code   <= r_shreg;
          r_key_ext    <= r_ext;
          r_key_rel    <= r_rel;
          r_ext        <= 1'b0;
          r_rel        <= 1'b0;
        end
      end else if (w_err) begin
        r_ext <= 1'b0;
        r_rel <= 1'b0;
      end
    end
  end

  assign bus.o_byte_valid   = r_byte_valid;
  assign bus.o_byte_data    = r_byte_data;
  assign bus.o_frame_err    = r_frame_err;
  assign bus.o_key_strobe   = r_key_strobe;
  assign bus.o_key_code     = r_key_code;
  assign bus.o_key_extended = r_key_ext;
  assign bus.o_key_released = r_key_rel;
endmodule

// File: tb/tb_ps2_host_rx.sv
// Bench for ps2_host_rx: table of whole frames, directed glitch/timeout/reset
// sequences, then random frames against a byte/key-level reference model.
module tb_ps2_host_rx;
  localparam int TIMEOUT = 4096;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
  } key_t;

  typedef struct {
    logic [7:0] d;
    bit         pflip;
    bit         stop;
    bit         ev;
    bit         ee;
    bit         ek;
    logic [7:0] kc;
    bit         kx;
    bit         kr;
  } vec_t;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  ps2_host_rx_if ifc();

  ps2_host_rx #(.FILTER_LEN(8), .TIMEOUT(TIMEOUT), .TIMEOUT_BITS(13)) dut (
    .i_clk_sys (clk_sys),
    .i_reset   (reset),
    .bus       (ifc.slave)
  );

  // Event recorder: everything seen on the outputs, in order.
  logic [7:0] q_byte[$];
  key_t       q_key[$];
  int         n_err    = 0;
  int         n_orphan = 0;

  always @(negedge clk_sys) begin
    if (!reset) begin
      if (ifc.o_byte_valid) q_byte.push_back(ifc.o_byte_data);
      if (ifc.o_frame_err) n_err++;
      if (ifc.o_key_strobe) begin
        q_key.push_back({ifc.o_key_code, ifc.o_key_extended, ifc.o_key_released});
        if (!ifc.o_byte_valid) n_orphan++;
      end
    end
  end

  int   total = 0, bad = 0;
  int   rd_byte = 0, rd_key = 0, err_seen = 0;
  logic [7:0] last_good = 8'h00;
  key_t last_key = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input bit ev,
                              input bit ee, input bit ek, input key_t kk);
    chk({tag, " byte_cnt"}, 32'(q_byte.size() - rd_byte), 32'(ev));
    if (ev && q_byte.size() > rd_byte) chk({tag, " byte"}, 32'(q_byte[rd_byte]), 32'(d));
    chk({tag, " err_cnt"}, 32'(n_err - err_seen), 32'(ee));
    chk({tag, " key_cnt"}, 32'(q_key.size() - rd_key), 32'(ek));
    if (ek && q_key.size() > rd_key) chk({tag, " key"}, 32'(q_key[rd_key]), 32'(kk));
    if (ev) last_good = d;
    if (ek) last_key = kk;
    chk({tag, " byte_data_hold"}, 32'(ifc.o_byte_data), 32'(last_good));
    chk({tag, " key_hold"},
        32'({ifc.o_key_code, ifc.o_key_extended, ifc.o_key_released}), 32'(last_key));
    chk({tag, " key_wo_valid"}, 32'(n_orphan), 32'd0);
    rd_byte  = q_byte.size();
    rd_key   = q_key.size();
    err_seen = n_err;
  endtask

  function automatic logic [10:0] mk(input logic [7:0] d, input bit pflip, input bit stop);
    return {stop, (~^d) ^ pflip, d, 1'b0};
  endfunction

  // Sends fr[0..nbits-1]; data changes mid-high, optional 3-cycle low glitch in one bit's high phase.
  task automatic send_bits(input logic [10:0] fr, input int nbits, input int hp, input int glitch_bit);
    for (int i = 0; i < nbits; i++) begin
      ifc.i_ps2_data = fr[i];
      if (i == glitch_bit) begin
        repeat (hp / 2) @(negedge clk_sys);
        ifc.i_ps2_clk = 1'b0;
        repeat (3) @(negedge clk_sys);
        ifc.i_ps2_clk = 1'b1;
        repeat (hp - hp / 2 - 3) @(negedge clk_sys);
      end else begin
        repeat (hp) @(negedge clk_sys);
      end
      ifc.i_ps2_clk = 1'b0;
      repeat (hp) @(negedge clk_sys);
      ifc.i_ps2_clk = 1'b1;
    end
    repeat (hp) @(negedge clk_sys);
    ifc.i_ps2_data = 1'b1;
    repeat (30) @(negedge clk_sys);
  endtask

  vec_t tbl[14];

  initial begin
    logic [7:0] d;
    bit         pf, st, m_ext, m_rel, good;

    tbl[0]  = '{8'h1C, 0, 1, 1, 0, 1, 8'h1C, 0, 0};
    tbl[1]  = '{8'hE0, 0, 1, 1, 0, 0, 8'h00, 0, 0};
    tbl[2]  = '{8'hF0, 0, 1, 1, 0, 0, 8'h00, 0, 0};
    tbl[3]  = '{8'h75, 0, 1, 1, 0, 1, 8'h75, 1, 1};
    tbl[4]  = '{8'h75, 0, 1, 1, 0, 1, 8'h75, 0, 0};
    tbl[5]  = '{8'h1C, 1, 1, 0, 1, 0, 8'h00, 0, 0};
    tbl[6]  = '{8'h1C, 0, 0, 0, 1, 0, 8'h00, 0, 0};
    tbl[7]  = '{8'hF0, 0, 1, 1, 0, 0, 8'h00, 0, 0};
    tbl[8]  = '{8'h6B, 0, 1, 1, 0, 1, 8'h6B, 0, 1};
    tbl[9]  = '{8'hE0, 0, 1, 1, 0, 0, 8'h00, 0, 0};
    tbl[10] = '{8'h29, 1, 1, 0, 1, 0, 8'h00, 0, 0};
    tbl[11] = '{8'h29, 0, 1, 1, 0, 1, 8'h29, 0, 0};
    tbl[12] = '{8'hE1, 0, 1, 1, 0, 1, 8'hE1, 0, 0};
    tbl[13] = '{8'hAA, 0, 1, 1, 0, 1, 8'hAA, 0, 0};

    ifc.i_ps2_clk  = 1'b1;
    ifc.i_ps2_data = 1'b1;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    repeat (20) @(negedge clk_sys);
    expect_frame("reset_state", 8'h00, 0, 0, 0, '0);
    chk("reset byte_valid", 32'(ifc.o_byte_valid), 0);
    chk("reset frame_err", 32'(ifc.o_frame_err), 0);
    chk("reset key_strobe", 32'(ifc.o_key_strobe), 0);

    for (int i = 0; i < 14; i++) begin
      send_bits(mk(tbl[i].d, tbl[i].pflip, tbl[i].stop), 11, 101, -1);
      expect_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].ev, tbl[i].ee, tbl[i].ek,
                   {tbl[i].kc, tbl[i].kx, tbl[i].kr});
    end

    // Glitches: idle, then inside a frame.
    ifc.i_ps2_clk = 1'b0;
    repeat (3) @(negedge clk_sys);
    ifc.i_ps2_clk = 1'b1;
    repeat (40) @(negedge clk_sys);
    expect_frame("glitch_idle", 8'h00, 0, 0, 0, '0);
    send_bits(mk(8'h29, 0, 1), 11, 101, 4);
    expect_frame("glitch_frame", 8'h29, 1, 0, 1, {8'h29, 1'b0, 1'b0});

    // Stalled frame after an E0 prefix.
    send_bits(mk(8'hE0, 0, 1), 11, 101, -1);
    expect_frame("to_prefix", 8'hE0, 1, 0, 0, '0);
    send_bits(mk(8'h29, 0, 1), 5, 101, -1);
    repeat (TIMEOUT + 10) @(negedge clk_sys);
    expect_frame("timeout", 8'h00, 0, 1, 0, '0);
    send_bits(mk(8'h29, 0, 1), 11, 101, -1);
    expect_frame("after_timeout", 8'h29, 1, 0, 1, {8'h29, 1'b0, 1'b0});

    // Reset in the middle of a frame, with an E0 flag armed.
    send_bits(mk(8'hE0, 0, 1), 11, 101, -1);
    expect_frame("rst_prefix", 8'hE0, 1, 0, 0, '0);
    send_bits(mk(8'h5A, 0, 1), 7, 101, -1);
    reset = 1'b1;
    @(negedge clk_sys);
    chk("rst byte_valid", 32'(ifc.o_byte_valid), 0);
    chk("rst byte_data", 32'(ifc.o_byte_data), 0);
    chk("rst frame_err", 32'(ifc.o_frame_err), 0);
    chk("rst key_strobe", 32'(ifc.o_key_strobe), 0);
    chk("rst key_code", 32'(ifc.o_key_code), 0);
    chk("rst key_ext", 32'(ifc.o_key_extended), 0);
    chk("rst key_rel", 32'(ifc.o_key_released), 0);
    reset = 1'b0;
    last_good = 8'h00;
    last_key  = '0;
    repeat (100) @(negedge clk_sys);
    expect_frame("post_reset", 8'h00, 0, 0, 0, '0);
    send_bits(mk(8'h5A, 0, 1), 11, 101, -1);
    expect_frame("after_reset", 8'h5A, 1, 0, 1, {8'h5A, 1'b0, 1'b0});

    // Random frames against a byte/key-level model.
    m_ext = 0;
    m_rel = 0;
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 7))
        0:       d = 8'hE0;
        1:       d = 8'hF0;
        default: d = 8'($urandom_range(0, 255));
      endcase
      pf   = ($urandom_range(0, 7) == 0);
      st   = ($urandom_range(0, 7) != 0);
      good = !pf && st;
      send_bits(mk(d, pf, st), 11, $urandom_range(12, 40), -1);
      if (!good) begin
        expect_frame($sformatf("rnd%0d_bad", n), d, 0, 1, 0, '0);
        m_ext = 0;
        m_rel = 0;
      end else if (d == 8'hE0) begin
        expect_frame($sformatf("rnd%0d_e0", n), d, 1, 0, 0, '0);
        m_ext = 1;
      end else if (d == 8'hF0) begin
        expect_frame($sformatf("rnd%0d_f0", n), d, 1, 0, 0, '0);
        m_rel = 1;
      end else begin
        expect_frame($sformatf("rnd%0d_key", n), d, 1, 0, 1, {d, m_ext, m_rel});
        m_ext = 0;
        m_rel = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
